// File: rtl/tri_edge_walker_if.sv
// Pixel-stream interface between the triangle edge walker (master) and the
// fragment shader or testbench (slave).
//
// Valid/ready semantics: the master raises out_valid with a pixel and holds
// every pixel field stable until the cycle where out_valid && out_ready is
// sampled high on a rising clk edge. That edge transfers the pixel. The slave
// may change out_ready freely. out_valid never depends combinationally on
// out_ready.
//
// Signals
//   start, x0..x2, y0..y2 : triangle request (slave -> master)
//   busy, done            : walk status (master -> slave)
//   out_valid, out_ready  : pixel handshake
//   px, py, visible, ua, va, wa, a, last : pixel payload (master -> slave)
//   dbg_state             : walker FSM state encoding, for observation only
interface tri_edge_walker_if #(
  parameter int XW = 10,
  parameter int YW = 9
);
  logic          start;
  logic [XW-1:0] x0, x1, x2;
  logic [YW-1:0] y0, y1, y2;
  logic          busy;
  logic          out_valid;
  logic          out_ready;
  logic [XW-1:0] px;
  logic [YW-1:0] py;
  logic          visible;
  logic [17:0]   ua, va, wa;
  logic [18:0]   a;
  logic          last;
  logic          done;
  logic [2:0]    dbg_state;

  modport master (
    input  start, x0, x1, x2, y0, y1, y2, out_ready,
    output busy, out_valid, px, py, visible, ua, va, wa, a, last, done,
           dbg_state
  );

  modport slave (
    output start, x0, x1, x2, y0, y1, y2, out_ready,
    input  busy, out_valid, px, py, visible, ua, va, wa, a, last, done,
           dbg_state
  );
endinterface

// File: rtl/tri_edge_walker.sv
// Triangle edge walker. It latches three screen-space vertices on start and
// sets up the three edge functions. It then walks the whole H_RES x V_RES frame
// in raster order and emits one pixel per handshake. Each pixel carries the
// edge values (ua/va/wa) and twice the triangle area (a).
//
// Ports
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : tri_edge_walker_if master modport (request, status, pixel stream)
module tri_edge_walker #(
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int XW    = 10,
  parameter int YW    = 9
) (
  input  logic             clk,
  input  logic             rst,
  tri_edge_walker_if.master bus
);

  localparam int DW = ((XW > YW) ? XW : YW) + 2;  // signed vertex difference
  localparam int PW = 2 * DW + 2;                 // setup product width
  localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP0 = 3'd1,
    SETUP1 = 3'd2,
    WALK   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t state;

  logic [XW-1:0]        vx0, vx1, vx2;
  logic [YW-1:0]        vy0, vy1, vy2;
  logic signed [DW-1:0] dxu, dyu, dxv, dyv, dxw, dyw;
  // Current-pixel edges, row-start edges, per-pixel and per-row steps.
  logic signed [20:0]   eu, ev, ew, ru, rv, rw;
  logic signed [20:0]   sxu, sxv, sxw, syu, syv, syw;

  // Edge value at the origin: E(0;A,B) = Ay*(Bx-Ax) - Ax*(By-Ay).
  function automatic logic signed [20:0] edge_at_origin(
    input logic [XW-1:0]        ax,
    input logic [YW-1:0]        ay,
    input logic signed [DW-1:0] dx,
    input logic signed [DW-1:0] dy
  );
    logic signed [PW-1:0] axs, ays, dxs, dys, e;
    axs = $signed(PW'(ax));
    ays = $signed(PW'(ay));
    dxs = PW'(dx);
    dys = PW'(dy);
    e   = ays * dxs - axs * dys;
    return e[20:0];
  endfunction

  // Non-negative edge clipped to the 18-bit output field.
  function automatic logic [17:0] sat18(input logic signed [20:0] e);
    return (e[20:18] != 3'd0) ? 18'h3FFFF : e[17:0];
  endfunction

  // {visible, ua, va, wa}; edge fields are zeroed outside the triangle.
  function automatic logic [54:0] pix_out(input logic signed [20:0] u,
                                          input logic signed [20:0] v,
                                          input logic signed [20:0] w);
    logic vis;
    vis = !u[20] && !v[20] && !w[20];
    return vis ? {1'b1, sat18(u), sat18(v), sat18(w)} : 55'd0;
  endfunction

  logic signed [20:0] eu0, ev0, ew0, s0, abs_s;
  logic signed [20:0] eu0n, ev0n, ew0n;
  logic signed [20:0] sxu0, sxv0, sxw0, syu0, syv0, syw0;
  logic               neg;
  logic               x_wrap, y_end;
  logic signed [20:0] nu, nv, nw;
  logic [XW-1:0]      nx;
  logic [YW-1:0]      ny;

  always_comb begin
    eu0   = edge_at_origin(vx1, vy1, dxu, dyu);
    ev0   = edge_at_origin(vx2, vy2, dxv, dyv);
    ew0   = edge_at_origin(vx0, vy0, dxw, dyw);
    s0    = eu0 + ev0 + ew0;
    // Clockwise winding gives a negative area; flip everything so the
    // inside of the triangle is always the non-negative half-plane.
    neg   = s0[20];
    abs_s = neg ? -s0 : s0;
    eu0n  = neg ? -eu0 : eu0;
    ev0n  = neg ? -ev0 : ev0;
    ew0n  = neg ? -ew0 : ew0;
    sxu0  = neg ? -21'(dyu) : 21'(dyu);
    sxv0  = neg ? -21'(dyv) : 21'(dyv);
    sxw0  = neg ? -21'(dyw) : 21'(dyw);
    syu0  = neg ? 21'(dxu) : -21'(dxu);
    syv0  = neg ? 21'(dxv) : -21'(dxv);
    syw0  = neg ? 21'(dxw) : -21'(dxw);

    x_wrap = (bus.px == X_LAST);
    y_end  = (bus.py == Y_LAST);
    nu = x_wrap ? ru + syu : eu + sxu;
    nv = x_wrap ? rv + syv : ev + sxv;
    nw = x_wrap ? rw + syw : ew + sxw;
    nx = x_wrap ? '0 : bus.px + 1'b1;
    ny = x_wrap ? bus.py + 1'b1 : bus.py;
  end

  assign bus.dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bus.busy      <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.last      <= 1'b0;
      bus.done      <= 1'b0;
      bus.visible   <= 1'b0;
      bus.px        <= '0;
      bus.py        <= '0;
      bus.ua        <= '0;
      bus.va        <= '0;
      bus.wa        <= '0;
      bus.a         <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            vx0 <= bus.x0; vx1 <= bus.x1; vx2 <= bus.x2;
            vy0 <= bus.y0; vy1 <= bus.y1; vy2 <= bus.y2;
            bus.busy <= 1'b1;
            state    <= SETUP0;
          end
        end
        SETUP0: begin
          dxu <= $signed(DW'(vx2)) - $signed(DW'(vx1));
          dyu <= $signed(DW'(vy2)) - $signed(DW'(vy1));
          dxv <= $signed(DW'(vx0)) - $signed(DW'(vx2));
          dyv <= $signed(DW'(vy0)) - $signed(DW'(vy2));
          dxw <= $signed(DW'(vx1)) - $signed(DW'(vx0));
          dyw <= $signed(DW'(vy1)) - $signed(DW'(vy0));
          state <= SETUP1;
        end
        SETUP1: begin
          if (s0 == 21'sd0) begin
            bus.done <= 1'b1;
            state    <= DONE;
          end else begin
            eu <= eu0n; ev <= ev0n; ew <= ew0n;
            ru <= eu0n; rv <= ev0n; rw <= ew0n;
            sxu <= sxu0; sxv <= sxv0; sxw <= sxw0;
            syu <= syu0; syv <= syv0; syw <= syw0;
            bus.a  <= abs_s[18:0];
            bus.px <= '0;
            bus.py <= '0;
            {bus.visible, bus.ua, bus.va, bus.wa} <= pix_out(eu0n, ev0n, ew0n);
            bus.last      <= (X_LAST == '0) && (Y_LAST == '0);
            bus.out_valid <= 1'b1;
            state         <= WALK;
          end
        end
        WALK: begin
          if (bus.out_valid && bus.out_ready) begin
            if (x_wrap && y_end) begin
              bus.out_valid <= 1'b0;
              bus.last      <= 1'b0;
              bus.done      <= 1'b1;
              state         <= DONE;
            end else begin
              eu <= nu; ev <= nv; ew <= nw;
              if (x_wrap) begin
                ru <= nu; rv <= nv; rw <= nw;
              end
              bus.px   <= nx;
              bus.py   <= ny;
              bus.last <= (nx == X_LAST) && (ny == Y_LAST);
              {bus.visible, bus.ua, bus.va, bus.wa} <= pix_out(nu, nv, nw);
            end
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tri_edge_walker.sv
module tb_tri_edge_walker;
  localparam int H  = 8;
  localparam int V  = 6;
  localparam int XW = 10;
  localparam int YW = 9;
  localparam int W  = XW + YW + 1 + 54 + 19 + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tri_edge_walker_if #(.XW(XW), .YW(YW)) bus ();

  tri_edge_walker #(.H_RES(H), .V_RES(V), .XW(XW), .YW(YW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int hs_cnt   = 0;
  int done_cnt = 0;
  int mx[3];
  int my[3];

  logic [W-1:0] exp_q[$];
  logic [17:0]  cap_ua[H][V];
  logic [17:0]  cap_va[H][V];
  logic [17:0]  cap_wa[H][V];
  logic         cap_vis[H][V];
  logic [18:0]  cap_a;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int edge_f(input int x, input int y, input int ax,
                                input int ay, input int bx, input int by);
    return (x - ax) * (by - ay) - (y - ay) * (bx - ax);
  endfunction

  function automatic logic [17:0] sat18(input int e);
    return 18'((e > 262143) ? 262143 : e);
  endfunction

  function automatic logic [W-1:0] model(input int x, input int y);
    int eu, ev, ew, s;
    logic vis;
    logic [17:0] u, v, w;
    eu = edge_f(x, y, mx[1], my[1], mx[2], my[2]);
    ev = edge_f(x, y, mx[2], my[2], mx[0], my[0]);
    ew = edge_f(x, y, mx[0], my[0], mx[1], my[1]);
    s  = eu + ev + ew;
    if (s < 0) begin
      eu = -eu; ev = -ev; ew = -ew; s = -s;
    end
    vis = (eu >= 0) && (ev >= 0) && (ew >= 0);
    u = vis ? sat18(eu) : 18'd0;
    v = vis ? sat18(ev) : 18'd0;
    w = vis ? sat18(ew) : 18'd0;
    return {XW'(x), YW'(y), vis, u, v, w, 19'(s), (x == H - 1) && (y == V - 1)};
  endfunction

  task automatic push_frame();
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++)
        exp_q.push_back(model(x, y));
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_with(input int ax0, input int ay0, input int ax1,
                            input int ay1, input int ax2, input int ay2);
    bus.x0 = XW'(ax0); bus.y0 = YW'(ay0);
    bus.x1 = XW'(ax1); bus.y1 = YW'(ay1);
    bus.x2 = XW'(ax2); bus.y2 = YW'(ay2);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic start_model();
    start_with(mx[0], my[0], mx[1], my[1], mx[2], my[2]);
  endtask

  // Waits for the done pulse (optionally randomising out_ready), then one
  // more cycle so the walker is back in IDLE.
  task automatic wait_done(input string name, input int budget, input bit rnd,
                           output int n);
    n = 0;
    while (!bus.done && n < budget) begin
      if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    check({name, "_done"}, bus.done, 1);
    bus.out_ready = 1'b1;
    if (bus.done) begin
      @(posedge clk); #1;
      check({name, "_busy_low"}, bus.busy, 0);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [W-1:0] snap;
  logic         stalled = 1'b0;

  always @(negedge clk) begin
    logic [W-1:0] cur, e;
    if (rst) begin
      stalled = 1'b0;
    end else begin
      cur = {bus.px, bus.py, bus.visible, bus.ua, bus.va, bus.wa, bus.a, bus.last};
      if (stalled) begin
        n_checks++;
        if (!bus.out_valid || cur !== snap) begin
          n_fail++;
          $display("FAIL stall_stable: got v=%0b %h expected v=1 %h", bus.out_valid, cur, snap);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        hs_cnt++;
        cap_ua[int'(bus.px)][int'(bus.py)]  = bus.ua;
        cap_va[int'(bus.px)][int'(bus.py)]  = bus.va;
        cap_wa[int'(bus.px)][int'(bus.py)]  = bus.wa;
        cap_vis[int'(bus.px)][int'(bus.py)] = bus.visible;
        cap_a = bus.a;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_pixel: got (%0d,%0d) expected none", bus.px, bus.py);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            n_fail++;
            $display("FAIL pixel (%0d,%0d): got %h expected %h", bus.px, bus.py, cur, e);
          end
        end
      end
      stalled = bus.out_valid && !bus.out_ready;
      snap    = cur;
      if (bus.done) done_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n, hs0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
    bus.x0 = '0; bus.x1 = '0; bus.x2 = '0;
    bus.y0 = '0; bus.y1 = '0; bus.y2 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_busy", bus.busy, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_last", bus.last, 0);
    check("rst_done", bus.done, 0);
    check("rst_pxpy", {bus.px, bus.py}, 0);
    check("rst_edges", {bus.ua, bus.va, bus.wa, bus.a}, 0);

    // T1: counter-clockwise right triangle, constant ready
    mx = '{0, 0, 4}; my = '{0, 4, 0};
    push_frame();
    start_model();
    check("t1_busy", bus.busy, 1);
    n = 1;
    while (!bus.out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("t1_latency", n, 3);
    wait_done("t1", 500, 1'b0, n);
    check("t1_queue_empty", exp_q.size(), 0);
    check("t1_ua00", cap_ua[0][0], 16);
    check("t1_va00", cap_va[0][0], 0);
    check("t1_wa00", cap_wa[0][0], 0);
    check("t1_vis00", cap_vis[0][0], 1);
    check("t1_uvw11", {cap_ua[1][1], cap_va[1][1], cap_wa[1][1]}, {18'd8, 18'd4, 18'd4});
    check("t1_vis32", cap_vis[3][2], 0);
    check("t1_a", cap_a, 16);
    check("t1_uvw21", {cap_ua[2][1], cap_va[2][1], cap_wa[2][1]}, {18'd4, 18'd4, 18'd8});

    // T2: same triangle, clockwise
    mx = '{0, 4, 0}; my = '{0, 0, 4};
    push_frame();
    start_model();
    wait_done("t2", 500, 1'b0, n);
    check("t2_queue_empty", exp_q.size(), 0);
    check("t2_uvw11", {cap_ua[1][1], cap_va[1][1], cap_wa[1][1]}, {18'd8, 18'd4, 18'd4});
    check("t2_uvw21", {cap_ua[2][1], cap_va[2][1], cap_wa[2][1]}, {18'd4, 18'd8, 18'd4});
    check("t2_vis32", cap_vis[3][2], 0);
    check("t2_a", cap_a, 16);

    // T3: degenerate triangle
    hs0 = hs_cnt;
    start_with(0, 0, 5, 5, 9, 9);
    wait_done("t3", 20, 1'b0, n);
    check("t3_done_latency", n + 1, 3);
    check("t3_no_pixels", hs_cnt - hs0, 0);

    // T4: random backpressure
    mx = '{0, 0, 4}; my = '{0, 4, 0};
    push_frame();
    hs0 = hs_cnt;
    start_model();
    wait_done("t4", 3000, 1'b1, n);
    check("t4_handshakes", hs_cnt - hs0, H * V);
    check("t4_queue_empty", exp_q.size(), 0);

    // T5: reset in the middle of a walk
    push_frame();
    hs0 = hs_cnt;
    start_model();
    n = 0;
    while (hs_cnt - hs0 < 10 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("t5_reached_mid", hs_cnt - hs0 >= 10, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t5_valid_low", bus.out_valid, 0);
    check("t5_busy_low", bus.busy, 0);
    @(posedge clk); #1;
    check("t5_still_quiet", bus.out_valid, 0);
    exp_q.delete();
    push_frame();
    hs0 = hs_cnt;
    start_model();
    wait_done("t5", 500, 1'b0, n);
    check("t5_restart_count", hs_cnt - hs0, H * V);
    check("t5_queue_empty", exp_q.size(), 0);

    // T6: large triangle, saturation, start ignored while busy
    mx = '{0, 0, 639}; my = '{0, 479, 0};
    push_frame();
    start_model();
    @(posedge clk); #1;
    start_with(0, 0, 0, 4, 4, 0);
    wait_done("t6", 500, 1'b0, n);
    check("t6_queue_empty", exp_q.size(), 0);
    check("t6_a", cap_a, 306081);
    check("t6_ua00_sat", cap_ua[0][0], 262143);
    check("t6_vis00", cap_vis[0][0], 1);
    repeat (3) @(posedge clk);
    #1 check("t6_no_restart", bus.busy, 0);

    check("done_pulses", done_cnt, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
